arty_boot_ctrl: RTL and testbench
=================================

# arty_boot_ctrl

Boot and reset sequencer between the Arty clock wizard and the PULPino SoC. Runs on the 50 MHz CPU clock, synchronizes the MMCM lock and the fetch push-button, holds the SoC in reset until the clock has been stable for a programmable time, then raises fetch enable either automatically or on a debounced button press. Loss of lock at any point drops the SoC back into reset and restarts the sequence.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `pll_locked_i` and `fetch_btn_i`; must be ≥2.
- `RST_HOLD_CYCLES`, 1024: cycles `locked_s` must stay high before SoC reset is released; must be ≥1.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles (1 ms at 50 MHz) required to accept a button level change; must be ≥1.
- `AUTO_FETCH`, 0: 1 raises fetch enable without a button press.
- `clk`, in, 1: CPU clock from the MMCM.
- `rst_n`, in, 1: asynchronous, active-low reset for all flops.
- `pll_locked_i`, in, 1: MMCM lock, asynchronous to `clk`.
- `fetch_btn_i`, in, 1: raw fetch push-button, active-high, asynchronous.
- `soc_rst_no`, out, 1: SoC reset, active-low, registered.
- `fetch_enable_o`, out, 1: SoC fetch enable, registered.
- `boot_state_o`, out, 2: current FSM state (RESET=0, HOLD=1, WAIT_FETCH=2, RUN=3).
- `lock_loss_cnt_o`, out, 8: saturating count of lock losses since `rst_n`.

## Operation
- Synchronizers: `pll_locked_i` and `fetch_btn_i` each pass through `SYNC_STAGES` flops. The outputs are `locked_s` and `btn_s`.
- Debouncer: runs in every state.
  - `btn_db` reset value is 0.
  - When `btn_s != btn_db`, the counter increments. When it reaches `DEBOUNCE_CYCLES-1` with the mismatch still present, `btn_db <= btn_s` on the next edge and the counter clears.
  - Any cycle with `btn_s == btn_db` clears the counter.
  - `press` is a 1-cycle pulse on a 0→1 transition of `btn_db`.
- FSM states and transitions (all registered):
  - RESET → HOLD when `locked_s=1`; hold counter cleared.
  - HOLD: hold counter increments each cycle.
    - → RESET if `locked_s=0`.
    - → WAIT_FETCH when the counter equals `RST_HOLD_CYCLES-1` and `locked_s=1`.
  - WAIT_FETCH:
    - → RESET if `locked_s=0`, with priority over the two transitions below.
    - → RUN when `AUTO_FETCH=1` (unconditional, next edge).
    - → RUN on `press` when `AUTO_FETCH=0`.
  - RUN → RESET if `locked_s=0`. Otherwise stays in RUN; further presses are ignored.
- Outputs are registered from the next state and therefore change on the same edge as the state:
  - `soc_rst_no` = 1 in WAIT_FETCH and RUN.
  - `fetch_enable_o` = 1 in RUN only.
- Lock loss means a transition from HOLD, WAIT_FETCH or RUN to RESET.
  - Each lock loss increments `lock_loss_cnt_o`, saturating at 255.
  - Remaining in RESET does not count.
  - The counter is cleared only by `rst_n`.
- After a lock loss the full sequence repeats. With `AUTO_FETCH=0` a new press is required.
  - A `press` pulse occurring outside WAIT_FETCH is discarded.
  - A button already held down when WAIT_FETCH is entered does not count; it must be released and pressed again.

## Timing
- Reset values while `rst_n=0`:
  - `soc_rst_no=0`, `fetch_enable_o=0`, `boot_state_o=0`, `lock_loss_cnt_o=0`.
  - All synchronizer, debounce and hold-counter flops are 0.
- Reset assertion: takes effect asynchronously; outputs go to reset values immediately, mid-sequence included.
- Reset deassertion: release is by the flops; no internal reset synchronizer.
- Release latency: with `pll_locked_i` sampled high at edge 1, HOLD is entered at edge `SYNC_STAGES+1`. `soc_rst_no` rises at edge `SYNC_STAGES+1+RST_HOLD_CYCLES`.
- `AUTO_FETCH=1`: `fetch_enable_o` rises exactly 1 cycle after `soc_rst_no`.
- Button press latency: `press` pulses `SYNC_STAGES+DEBOUNCE_CYCLES` cycles after the raw edge, if the input is stable. `fetch_enable_o` rises 1 cycle after `press`.
- Lock drop latency: `pll_locked_i` low is seen at `locked_s` after `SYNC_STAGES` edges. `soc_rst_no` and `fetch_enable_o` fall on the next edge, together.
- Glitch filtering: a lock glitch shorter than one clock period may be missed. Any glitch that reaches `locked_s` forces RESET.

## Test plan
1. Release sequence: `SYNC_STAGES=2`, `RST_HOLD_CYCLES=16`, `AUTO_FETCH=1`; `pll_locked_i` high before edge 1.
   - Required: `soc_rst_no` rises at edge 19; `fetch_enable_o` rises at edge 20; `boot_state_o` steps 0→1→2→3.
2. Debounce: `AUTO_FETCH=0`, `DEBOUNCE_CYCLES=8`, in WAIT_FETCH.
   - Stimulus: a 5-cycle button pulse, then a 20-cycle pulse.
   - Required: `fetch_enable_o` stays 0 after the 5-cycle pulse; it rises 2+8+1 cycles after the start of the 20-cycle pulse.
3. Lock loss in RUN: drop `pll_locked_i` for 3 cycles.
   - Required: `soc_rst_no` and `fetch_enable_o` fall together 3 edges after the drop; `lock_loss_cnt_o` = 1.
   - Required after relock: the full 16-cycle hold repeats.
4. Lock loss in HOLD: drop lock at hold count 10.
   - Required: return to RESET; `soc_rst_no` never pulses high; on relock the hold counter restarts from 0.
5. Button handling outside WAIT_FETCH: press during HOLD, and hold the button through entry to WAIT_FETCH.
   - Required: no RUN until the button is released and pressed again.
6. Saturation and async reset: force 300 lock losses.
   - Required: `lock_loss_cnt_o` = 255.
   - Required: asserting `rst_n` mid-RUN zeros all outputs without a clock edge.

Source files
------------

// File: rtl/arty_boot_ctrl.sv
// arty_boot_ctrl: boot/reset sequencer between the Arty clock wizard and the
// PULPino SoC. Synchronizes MMCM lock and the fetch button, holds the SoC in
// reset until lock has been stable for RST_HOLD_CYCLES, then raises fetch
// enable automatically or on a debounced button press. Any loss of lock drops
// the SoC back into reset and restarts the sequence.
module arty_boot_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int RST_HOLD_CYCLES = 1024,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int AUTO_FETCH      = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked_i,
    input  logic       fetch_btn_i,
    output logic       soc_rst_no,
    output logic       fetch_enable_o,
    output logic [1:0] boot_state_o,
    output logic [7:0] lock_loss_cnt_o
);

    // Counter widths: hold counter spans 0..RST_HOLD_CYCLES-1, debounce
    // counter spans 0..DEBOUNCE_CYCLES-1; never narrower than one bit.
    localparam int HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET      = 2'd0,
        ST_HOLD       = 2'd1,
        ST_WAIT_FETCH = 2'd2,
        ST_RUN        = 2'd3
    } state_e;

    // Synchronizer chains: bit 0 samples the raw pin, the top bit is the
    // metastability-safe copy used by the rest of the design.
    logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0] btn_sync_q,  btn_sync_d;
    logic                   locked_s;
    logic                   btn_s;

    // Debouncer state.
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            btn_db_q, btn_db_d;
    logic            btn_db_prev_q, btn_db_prev_d;
    logic            press;

    // Sequencer state.
    state_e          state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]      lock_loss_cnt_q, lock_loss_cnt_d;
    logic            soc_rst_n_q, soc_rst_n_d;
    logic            fetch_en_q, fetch_en_d;
    logic            lock_loss;

    assign locked_s = lock_sync_q[SYNC_STAGES-1];
    assign btn_s    = btn_sync_q[SYNC_STAGES-1];

    // Shift the raw lock and button levels into their synchronizer chains.
    always_comb begin
        lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
        btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0],  fetch_btn_i};
    end

    // Debounce: accept a new button level only after it has differed from the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        db_cnt_d      = db_cnt_q;
        btn_db_d      = btn_db_q;
        btn_db_prev_d = btn_db_q;
        if (btn_s != btn_db_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_d = btn_s;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // A press is the single cycle where the debounced level has just risen.
    // Presses outside WAIT_FETCH are simply not looked at, so a button held
    // through entry to WAIT_FETCH must be released and pressed again.
    assign press = btn_db_q & ~btn_db_prev_q;

    // Next-state logic for the boot sequence, lock-loss counting and the
    // registered SoC controls derived from the next state.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            ST_RESET: begin
                if (locked_s) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d = ST_RESET;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_FETCH;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_WAIT_FETCH: begin
                if (!locked_s) begin
                    state_d = ST_RESET;
                end else if ((AUTO_FETCH != 0) || press) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d = ST_RESET;
                end
            end
            default: state_d = ST_RESET;
        endcase

        // Only a fall back into RESET from an active state counts as a loss.
        lock_loss       = (state_q != ST_RESET) && (state_d == ST_RESET);
        lock_loss_cnt_d = lock_loss_cnt_q;
        if (lock_loss && (lock_loss_cnt_q != 8'hFF)) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
        end

        soc_rst_n_d = (state_d == ST_WAIT_FETCH) || (state_d == ST_RUN);
        fetch_en_d  = (state_d == ST_RUN);
    end

    // All state registers; rst_n clears every flop asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_sync_q     <= '0;
            btn_sync_q      <= '0;
            db_cnt_q        <= '0;
            btn_db_q        <= 1'b0;
            btn_db_prev_q   <= 1'b0;
            state_q         <= ST_RESET;
            hold_cnt_q      <= '0;
            lock_loss_cnt_q <= 8'd0;
            soc_rst_n_q     <= 1'b0;
            fetch_en_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values from
            // before this edge, regardless of statement order.
            lock_sync_q     <= lock_sync_d;
            btn_sync_q      <= btn_sync_d;
            db_cnt_q        <= db_cnt_d;
            btn_db_q        <= btn_db_d;
            btn_db_prev_q   <= btn_db_prev_d;
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            lock_loss_cnt_q <= lock_loss_cnt_d;
            soc_rst_n_q     <= soc_rst_n_d;
            fetch_en_q      <= fetch_en_d;
        end
    end

    assign soc_rst_no      = soc_rst_n_q;
    assign fetch_enable_o  = fetch_en_q;
    assign boot_state_o    = state_q;
    assign lock_loss_cnt_o = lock_loss_cnt_q;

endmodule

// File: tb/tb_arty_boot_ctrl.sv
// tb_arty_boot_ctrl: scoreboard bench for arty_boot_ctrl. Two instances share
// all inputs: u_man (AUTO_FETCH=0) and u_auto (AUTO_FETCH=1). Expectations are
// queued as (cycle, instance, signal, value) when stimulus is driven and are
// popped and compared on the falling edge of the cycle they refer to. Cycle N
// means "just after rising edge N counted from rst_n release".
module tb_arty_boot_ctrl;

    localparam int SS   = 2;
    localparam int HOLD = 16;
    localparam int DB   = 8;

    // Signal selectors and instance ids for scoreboard entries.
    localparam int S_RST   = 0;
    localparam int S_FE    = 1;
    localparam int S_STATE = 2;
    localparam int S_CNT   = 3;
    localparam int D_MAN   = 0;
    localparam int D_AUTO  = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       fetch_btn = 1'b0;

    logic       m_rst_n, a_rst_n;
    logic       m_fe, a_fe;
    logic [1:0] m_state, a_state;
    logic [7:0] m_cnt, a_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int    cyc;
        string tag;
        int    dut;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];

    arty_boot_ctrl #(
        .SYNC_STAGES(SS), .RST_HOLD_CYCLES(HOLD),
        .DEBOUNCE_CYCLES(DB), .AUTO_FETCH(0)
    ) u_man (
        .clk(clk), .rst_n(rst_n), .pll_locked_i(pll_locked), .fetch_btn_i(fetch_btn),
        .soc_rst_no(m_rst_n), .fetch_enable_o(m_fe),
        .boot_state_o(m_state), .lock_loss_cnt_o(m_cnt)
    );

    arty_boot_ctrl #(
        .SYNC_STAGES(SS), .RST_HOLD_CYCLES(HOLD),
        .DEBOUNCE_CYCLES(DB), .AUTO_FETCH(1)
    ) u_auto (
        .clk(clk), .rst_n(rst_n), .pll_locked_i(pll_locked), .fetch_btn_i(fetch_btn),
        .soc_rst_no(a_rst_n), .fetch_enable_o(a_fe),
        .boot_state_o(a_state), .lock_loss_cnt_o(a_cnt)
    );

    always #10 clk = ~clk;

    // Edge counter, zero while rst_n is low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int act_of(input int dut, input int sel);
        if (dut == D_MAN) begin
            case (sel)
                S_RST:   return int'(m_rst_n);
                S_FE:    return int'(m_fe);
                S_STATE: return int'(m_state);
                default: return int'(m_cnt);
            endcase
        end else begin
            case (sel)
                S_RST:   return int'(a_rst_n);
                S_FE:    return int'(a_fe);
                S_STATE: return int'(a_state);
                default: return int'(a_cnt);
            endcase
        end
    endfunction

    // Insert an expectation, keeping the queue ordered by cycle.
    task automatic exp_at(input int c, input string tag, input int dut,
                          input int sel, input int val);
        exp_t e;
        int   idx;
        e.cyc = c; e.tag = tag; e.dut = dut; e.sel = sel; e.val = val;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic exp_both(input int c, input string tag, input int sel, input int val);
        exp_at(c, {tag, "_man"},  D_MAN,  sel, val);
        exp_at(c, {tag, "_auto"}, D_AUTO, sel, val);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Scoreboard monitor: compare every expectation due at this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && rst_n && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            check(e.tag, act_of(e.dut, e.sel), e.val);
        end
    end

    initial begin
        // Reset state, with lock already high at the pins.
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_soc_rst_man", int'(m_rst_n), 0);
        check("rst_fe_man",      int'(m_fe), 0);
        check("rst_state_man",   int'(m_state), 0);
        check("rst_cnt_man",     int'(m_cnt), 0);
        check("rst_soc_rst_auto", int'(a_rst_n), 0);
        check("rst_state_auto",  int'(a_state), 0);

        // 1: release sequence. Lock sampled high at edge 1.
        exp_both(2,  "t1_state_reset", S_STATE, 0);
        exp_both(3,  "t1_state_hold",  S_STATE, 1);
        exp_both(18, "t1_state_hold_end", S_STATE, 1);
        exp_both(18, "t1_soc_rst_lo",  S_RST, 0);
        exp_both(19, "t1_soc_rst_hi",  S_RST, 1);
        exp_both(19, "t1_state_wait",  S_STATE, 2);
        exp_at(19, "t1_fe_lo_auto",  D_AUTO, S_FE, 0);
        exp_at(20, "t1_fe_hi_auto",  D_AUTO, S_FE, 1);
        exp_at(20, "t1_state_run_auto", D_AUTO, S_STATE, 3);
        exp_at(24, "t1_fe_lo_man",   D_MAN, S_FE, 0);
        exp_at(24, "t1_state_wait_man", D_MAN, S_STATE, 2);
        rst_n = 1'b1;

        // 2: debounce. 5-cycle pulse sampled at edges 26..30 is rejected.
        wait_cyc(25);
        fetch_btn = 1'b1;
        exp_at(39, "t2_short_fe_man",    D_MAN, S_FE, 0);
        exp_at(39, "t2_short_state_man", D_MAN, S_STATE, 2);
        wait_cyc(30);
        fetch_btn = 1'b0;
        // 20-cycle pulse first sampled at edge 41: fetch at 41 + 2 + 8.
        wait_cyc(40);
        fetch_btn = 1'b1;
        exp_at(50, "t2_long_fe_lo_man", D_MAN, S_FE, 0);
        exp_at(51, "t2_long_fe_hi_man", D_MAN, S_FE, 1);
        exp_at(51, "t2_long_run_man",   D_MAN, S_STATE, 3);
        wait_cyc(60);
        fetch_btn = 1'b0;

        // 3: lock loss in RUN, low at edges 71..73.
        wait_cyc(70);
        pll_locked = 1'b0;
        exp_both(72, "t3_soc_rst_still", S_RST, 1);
        exp_both(72, "t3_fe_still",      S_FE, 1);
        exp_both(73, "t3_soc_rst_fall",  S_RST, 0);
        exp_both(73, "t3_fe_fall",       S_FE, 0);
        exp_both(73, "t3_state_reset",   S_STATE, 0);
        exp_both(73, "t3_cnt",           S_CNT, 1);
        wait_cyc(73);
        pll_locked = 1'b1;
        // Relock sampled at edge 74: HOLD at 76, release at 92.
        exp_both(75, "t3_state_reset2", S_STATE, 0);
        exp_both(76, "t3_state_hold",   S_STATE, 1);
        exp_both(80, "t3_cnt_no_recount", S_CNT, 1);
        exp_both(91, "t3_relock_rst_lo", S_RST, 0);
        exp_both(92, "t3_relock_rst_hi", S_RST, 1);
        exp_at(93, "t3_relock_fe_auto", D_AUTO, S_FE, 1);
        exp_at(95, "t3_relock_fe_man",  D_MAN, S_FE, 0);
        exp_at(95, "t3_relock_wait_man", D_MAN, S_STATE, 2);

        // 4: lock loss in HOLD. Bounce lock to restart, then drop at count 10.
        wait_cyc(100);
        pll_locked = 1'b0;
        exp_both(103, "t4_cnt2", S_CNT, 2);
        wait_cyc(103);
        pll_locked = 1'b1;             // sampled at 104: HOLD at 106
        exp_both(106, "t4_state_hold", S_STATE, 1);
        wait_cyc(116);                 // hold count is 10 here
        pll_locked = 1'b0;
        exp_both(117, "t4_rst_lo_a", S_RST, 0);
        exp_both(118, "t4_state_hold_b", S_STATE, 1);
        exp_both(118, "t4_rst_lo_b", S_RST, 0);
        exp_both(119, "t4_state_reset", S_STATE, 0);
        exp_both(119, "t4_rst_lo_c", S_RST, 0);
        exp_both(119, "t4_cnt3", S_CNT, 3);
        wait_cyc(119);
        pll_locked = 1'b1;             // sampled at 120: HOLD at 122
        exp_both(121, "t4_rst_lo_d", S_RST, 0);
        exp_both(122, "t4_state_hold2", S_STATE, 1);
        exp_both(137, "t4_full_hold_lo", S_RST, 0);
        exp_both(138, "t4_full_hold_hi", S_RST, 1);

        // 5: button pressed during HOLD, held into WAIT_FETCH, then re-pressed.
        wait_cyc(124);
        fetch_btn = 1'b1;
        exp_at(140, "t5_held_wait_man", D_MAN, S_STATE, 2);
        exp_at(150, "t5_held_fe_man",   D_MAN, S_FE, 0);
        wait_cyc(150);
        fetch_btn = 1'b0;
        exp_at(165, "t5_release_wait_man", D_MAN, S_STATE, 2);
        exp_at(165, "t5_release_fe_man",   D_MAN, S_FE, 0);
        wait_cyc(170);
        fetch_btn = 1'b1;
        exp_at(180, "t5_repress_fe_lo_man", D_MAN, S_FE, 0);
        exp_at(181, "t5_repress_fe_hi_man", D_MAN, S_FE, 1);
        exp_at(181, "t5_repress_run_man",   D_MAN, S_STATE, 3);
        wait_cyc(190);
        fetch_btn = 1'b0;

        // 6: saturation. Toggle lock every cycle for ~350 losses, then settle.
        wait_cyc(200);
        for (int i = 0; i < 700; i++) begin
            pll_locked = ~pll_locked;
            @(negedge clk);
        end
        pll_locked = 1'b1;
        exp_both(925, "t6_cnt_sat", S_CNT, 255);
        exp_at(925, "t6_run_auto", D_AUTO, S_STATE, 3);
        exp_at(925, "t6_fe_auto",  D_AUTO, S_FE, 1);
        exp_at(925, "t6_rst_man",  D_MAN, S_RST, 1);
        wait_cyc(930);
        check("sb_all_consumed", sb.size(), 0);

        // Asynchronous reset mid-RUN, well away from any rising edge.
        #3;
        rst_n = 1'b0;
        #1;
        check("areset_soc_rst_auto", int'(a_rst_n), 0);
        check("areset_fe_auto",      int'(a_fe), 0);
        check("areset_state_auto",   int'(a_state), 0);
        check("areset_cnt_auto",     int'(a_cnt), 0);
        check("areset_cnt_man",      int'(m_cnt), 0);
        check("areset_soc_rst_man",  int'(m_rst_n), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
